// File: rtl/centroid_calc_if.sv
// centroid_calc_if
//
// Bundles the video pass-through and centroid result signals of centroid_calc.
//   master : drives the incoming video (de_in, h_sync_in, v_sync_in, mask_in)
//            and observes the delayed video plus the centroid result.
//   slave  : the centroid_calc block itself.
//
// Handshake: the result path is a valid-only strobe with no ready.
// center_valid is high for exactly one cycle when x_center/y_center/no_object
// are reloaded, and the consumer must take them in that cycle. The three
// result outputs hold their values between strobes. busy is status only.
// state_dbg mirrors the internal FSM state (IDLE=0, DIV=1, LOAD=2).
interface centroid_calc_if;
    logic        de_in;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        mask_in;
    logic        de_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic [10:0] x_center;
    logic [10:0] y_center;
    logic        center_valid;
    logic        no_object;
    logic        busy;
    logic [1:0]  state_dbg;

    modport master (
        output de_in, h_sync_in, v_sync_in, mask_in,
        input  de_out, h_sync_out, v_sync_out,
        input  x_center, y_center, center_valid, no_object, busy, state_dbg
    );

    modport slave (
        input  de_in, h_sync_in, v_sync_in, mask_in,
        output de_out, h_sync_out, v_sync_out,
        output x_center, y_center, center_valid, no_object, busy, state_dbg
    );
endinterface

// File: rtl/centroid_calc.sv
// centroid_calc
//
// Accumulates the zeroth (N) and first (Sx, Sy) moments of a binary object
// mask over one frame, snapshots them on the rising edge of v_sync_in and
// divides them during vertical blanking with two parallel restoring dividers
// (one quotient bit per cycle, 32 cycles). The result is floor(Sx/N),
// floor(Sy/N). Video sync/enable pass through with a 3-cycle delay.
//
// Ports:
//   clk  - pixel clock, all logic on the rising edge
//   rst  - synchronous, active-high reset
//   vid  - centroid_calc_if.slave: video in, delayed video out, result
//          (x_center, y_center, center_valid, no_object, busy, state_dbg)
module centroid_calc #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic           clk,
    input  logic           rst,
    centroid_calc_if.slave vid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
    localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  de_d;
    logic [2:0]  hs_d;
    logic [2:0]  vs_d;

    logic        prev_vsync;
    logic        frame_end;
    logic        pixel_hit;

    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic [19:0] n_acc;
    logic [31:0] sx_acc;
    logic [31:0] sy_acc;

    // Divider working registers. qx_sh/qy_sh start as the dividends and
    // shift left each step; the quotient bits fill in from the right, so
    // after 32 steps they hold the quotients.
    logic [19:0] div_n;
    logic [31:0] qx_sh;
    logic [31:0] qy_sh;
    logic [19:0] rx;
    logic [19:0] ry;
    logic [5:0]  iter;
    logic        snap_zero;

    logic [20:0] tx;
    logic [20:0] ty;
    logic [20:0] dx;
    logic [20:0] dy;
    logic        gex;
    logic        gey;
    logic [19:0] rx_nxt;
    logic [19:0] ry_nxt;

    assign frame_end = vid.v_sync_in & ~prev_vsync;
    // vsync has priority: a pixel arriving with vsync high is not counted.
    assign pixel_hit = vid.de_in & ~vid.v_sync_in & vid.mask_in;

    // ---------------- 3-cycle video delay line ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            de_d <= '0;
            hs_d <= '0;
            vs_d <= '0;
        end else begin
            de_d <= {de_d[1:0], vid.de_in};
            hs_d <= {hs_d[1:0], vid.h_sync_in};
            vs_d <= {vs_d[1:0], vid.v_sync_in};
        end
    end

    assign vid.de_out     = de_d[2];
    assign vid.h_sync_out = hs_d[2];
    assign vid.v_sync_out = vs_d[2];

    // ---------------- position counters and accumulators ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_vsync <= 1'b0;
            x_pos      <= '0;
            y_pos      <= '0;
            n_acc      <= '0;
            sx_acc     <= '0;
            sy_acc     <= '0;
        end else begin
            prev_vsync <= vid.v_sync_in;

            if (vid.v_sync_in) begin
                x_pos <= '0;
                y_pos <= '0;
            end else if (vid.de_in) begin
                if (x_pos == X_LAST) begin
                    x_pos <= '0;
                    y_pos <= (y_pos == Y_LAST) ? 11'd0 : y_pos + 11'd1;
                end else begin
                    x_pos <= x_pos + 11'd1;
                end
            end

            if (frame_end) begin
                n_acc  <= '0;
                sx_acc <= '0;
                sy_acc <= '0;
            end else if (pixel_hit) begin
                n_acc  <= n_acc + 20'd1;
                sx_acc <= sx_acc + {21'd0, x_pos};
                sy_acc <= sy_acc + {21'd0, y_pos};
            end
        end
    end

    // ---------------- one restoring-division step ----------------
    // Partial remainder is always < div_n, so the shifted trial value fits
    // in 21 bits and the restored remainder fits back into 20.
    always_comb begin
        tx     = {rx, qx_sh[31]};
        ty     = {ry, qy_sh[31]};
        dx     = tx - {1'b0, div_n};
        dy     = ty - {1'b0, div_n};
        gex    = (tx >= {1'b0, div_n});
        gey    = (ty >= {1'b0, div_n});
        rx_nxt = gex ? dx[19:0] : tx[19:0];
        ry_nxt = gey ? dy[19:0] : ty[19:0];
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // A frame end in any state restarts with the fresh snapshot, which
    // discards any division or load still in flight.
    always_comb begin
        state_nxt = state;
        if (frame_end) begin
            state_nxt = (n_acc == 20'd0) ? LOAD : DIV;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                DIV:     state_nxt = (iter == 6'd31) ? LOAD : DIV;
                LOAD:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign vid.busy      = (state != IDLE);
    assign vid.state_dbg = state;

    // ---------------- divider datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_n     <= '0;
            qx_sh     <= '0;
            qy_sh     <= '0;
            rx        <= '0;
            ry        <= '0;
            iter      <= '0;
            snap_zero <= 1'b1;
        end else if (frame_end) begin
            div_n     <= n_acc;
            qx_sh     <= sx_acc;
            qy_sh     <= sy_acc;
            rx        <= '0;
            ry        <= '0;
            iter      <= '0;
            snap_zero <= (n_acc == 20'd0);
        end else if (state == DIV) begin
            qx_sh <= {qx_sh[30:0], gex};
            qy_sh <= {qy_sh[30:0], gey};
            rx    <= rx_nxt;
            ry    <= ry_nxt;
            iter  <= iter + 6'd1;
        end
    end

    // ---------------- result registers ----------------
    // An empty frame keeps the previous coordinates and only flags no_object.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid.x_center     <= '0;
            vid.y_center     <= '0;
            vid.center_valid <= 1'b0;
            vid.no_object    <= 1'b1;
        end else begin
            vid.center_valid <= 1'b0;
            if (!frame_end && state == LOAD) begin
                vid.center_valid <= 1'b1;
                vid.no_object    <= snap_zero;
                if (!snap_zero) begin
                    vid.x_center <= qx_sh[10:0];
                    vid.y_center <= qy_sh[10:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_centroid_calc.sv
// tb_centroid_calc
//
// Bench for centroid_calc at 64x64. Frames are driven from a mask image;
// expected centroid results (with the cycle they must appear on) are pushed
// into exp_q when the vsync rise is driven and popped by a monitor when
// center_valid fires. The monitor also checks the 3-cycle video delay and
// that result outputs stay stable between strobes.
module tb_centroid_calc;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int QW = 55;   // {cycle[31:0], no_object, x[10:0], y[10:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    centroid_calc_if vif();

    centroid_calc #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .vid (vif)
    );

    // ---------------- scoreboard state ----------------
    logic [QW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    logic          mask_mem [0:H-1][0:W-1];
    logic [10:0]   hold_x = '0;
    logic [10:0]   hold_y = '0;
    logic [10:0]   cur_x  = '0;
    logic [10:0]   cur_y  = '0;
    logic          cur_no = 1'b1;
    logic [2:0]    hist0  = '0;
    logic [2:0]    hist1  = '0;
    logic [2:0]    hist2  = '0;

    // ---------------- monitor ----------------
    task automatic monitor_loop();
        logic [QW-1:0] e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (rst) begin
                hist0  = '0;
                hist1  = '0;
                hist2  = '0;
                cur_x  = '0;
                cur_y  = '0;
                cur_no = 1'b1;
            end else begin
                hist2 = hist1;
                hist1 = hist0;
                hist0 = {vif.de_in, vif.h_sync_in, vif.v_sync_in};
                n_vec++;
                if ({vif.de_out, vif.h_sync_out, vif.v_sync_out} !== hist2) begin
                    n_err++;
                    $display("FAIL delay_line: cycle %0d got de/hs/vs=%b expected %b",
                             cyc, {vif.de_out, vif.h_sync_out, vif.v_sync_out}, hist2);
                end
            end

            if (vif.center_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid: center_valid=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (32'(cyc) !== e[54:23]) begin
                        n_err++;
                        $display("FAIL valid_cycle: got cycle %0d expected %0d", cyc, e[54:23]);
                    end
                    n_vec++;
                    if (vif.no_object !== e[22]) begin
                        n_err++;
                        $display("FAIL no_object: got %b expected %b", vif.no_object, e[22]);
                    end
                    n_vec++;
                    if (vif.x_center !== e[21:11]) begin
                        n_err++;
                        $display("FAIL x_center: got %0d expected %0d", vif.x_center, e[21:11]);
                    end
                    n_vec++;
                    if (vif.y_center !== e[10:0]) begin
                        n_err++;
                        $display("FAIL y_center: got %0d expected %0d", vif.y_center, e[10:0]);
                    end
                    cur_no = e[22];
                    cur_x  = e[21:11];
                    cur_y  = e[10:0];
                end
            end else begin
                n_vec++;
                if ({vif.no_object, vif.x_center, vif.y_center} !== {cur_no, cur_x, cur_y}) begin
                    n_err++;
                    $display("FAIL hold_outputs: cycle %0d got no=%b x=%0d y=%0d expected no=%b x=%0d y=%0d",
                             cyc, vif.no_object, vif.x_center, vif.y_center, cur_no, cur_x, cur_y);
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_mask();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                mask_mem[y][x] = 1'b0;
    endtask

    task automatic set_px(input int x, input int y);
        mask_mem[y][x] = 1'b1;
    endtask

    task automatic drive_frame();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                @(negedge clk);
                vif.de_in     = 1'b1;
                vif.mask_in   = mask_mem[y][x];
                vif.h_sync_in = 1'b0;
            end
            @(negedge clk);
            vif.de_in     = 1'b0;
            vif.mask_in   = 1'b0;
            vif.h_sync_in = 1'b1;
            @(negedge clk);
            vif.h_sync_in = 1'b0;
        end
    endtask

    // Raises vsync (with an object pixel that must be ignored) and, when
    // push is set, queues the expected result computed from mask_mem.
    task automatic end_frame(input bit push, output int e0);
        logic [31:0] n, sx, sy;
        n = 0; sx = 0; sy = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (mask_mem[y][x]) begin
                    n  = n + 1;
                    sx = sx + 32'(x);
                    sy = sy + 32'(y);
                end
        @(negedge clk);
        vif.v_sync_in = 1'b1;
        vif.de_in     = 1'b1;
        vif.mask_in   = 1'b1;
        e0 = cyc + 1;
        if (push) begin
            if (n == 0) begin
                exp_q.push_back({32'(e0 + 1), 1'b1, hold_x, hold_y});
            end else begin
                hold_x = 11'(sx / n);
                hold_y = 11'(sy / n);
                exp_q.push_back({32'(e0 + 33), 1'b0, hold_x, hold_y});
            end
        end
        @(negedge clk);
        vif.de_in   = 1'b0;
        vif.mask_in = 1'b0;
        repeat (2) @(negedge clk);
        vif.v_sync_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: %0d results still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (10) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({vif.x_center, vif.y_center, vif.center_valid, vif.no_object, vif.busy} !==
            {11'd0, 11'd0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got x=%0d y=%0d v=%b no=%b busy=%b expected 0 0 0 1 0",
                     vif.x_center, vif.y_center, vif.center_valid, vif.no_object, vif.busy);
        end
        n_vec++;
        if (vif.state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected 0", vif.state_dbg);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_pixel();
        int e0;
        clear_mask();
        set_px(10, 20);
        drive_frame();
        end_frame(1'b1, e0);
        while (cyc < e0 + 3) begin @(posedge clk); #3; end
        n_vec++;
        if (vif.busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_during_div: got %b expected 1", vif.busy);
        end
        while (cyc < e0 + 33) begin @(posedge clk); #3; end
        n_vec++;
        if (vif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_after_load: got %b expected 0", vif.busy);
        end
        wait_drain("single_pixel");
    endtask

    task automatic test_block();
        int e0;
        clear_mask();
        for (int y = 8; y <= 11; y++)
            for (int x = 8; x <= 11; x++)
                set_px(x, y);
        drive_frame();
        end_frame(1'b1, e0);
        wait_drain("block");
    endtask

    task automatic test_corners_and_full();
        int e0;
        clear_mask();
        set_px(0, 0);
        set_px(63, 63);
        drive_frame();
        end_frame(1'b1, e0);
        wait_drain("corners");
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                set_px(x, y);
        drive_frame();
        end_frame(1'b1, e0);
        wait_drain("full_frame");
    endtask

    task automatic test_empty_frame();
        int e0;
        clear_mask();
        set_px(10, 20);
        drive_frame();
        end_frame(1'b1, e0);
        wait_drain("pre_empty");
        clear_mask();
        drive_frame();
        end_frame(1'b1, e0);
        wait_drain("empty");
    endtask

    task automatic test_reset_mid_div();
        int e0;
        clear_mask();
        set_px(30, 30);
        drive_frame();
        end_frame(1'b0, e0);
        while (cyc < e0 + 9) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({vif.x_center, vif.y_center, vif.center_valid, vif.no_object, vif.busy} !==
            {11'd0, 11'd0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_div: got x=%0d y=%0d v=%b no=%b busy=%b expected 0 0 0 1 0",
                     vif.x_center, vif.y_center, vif.center_valid, vif.no_object, vif.busy);
        end
        rst = 1'b0;
        hold_x = '0;
        hold_y = '0;
        repeat (40) @(negedge clk);
        clear_mask();
        set_px(5, 7);
        drive_frame();
        end_frame(1'b1, e0);
        wait_drain("after_reset");
    endtask

    task automatic test_back_to_back();
        int e0, e1;
        clear_mask();
        set_px(40, 40);
        drive_frame();
        @(negedge clk);
        vif.v_sync_in = 1'b1;
        e0 = cyc + 1;
        repeat (3) @(negedge clk);
        vif.v_sync_in = 1'b0;
        // short second frame: five object pixels at x=0..4 on row 0
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vif.de_in   = 1'b1;
            vif.mask_in = 1'b1;
        end
        @(negedge clk);
        vif.de_in   = 1'b0;
        vif.mask_in = 1'b0;
        while (cyc < e0 + 14) @(negedge clk);
        vif.v_sync_in = 1'b1;
        e1 = cyc + 1;
        hold_x = 11'((0 + 1 + 2 + 3 + 4) / 5);
        hold_y = 11'd0;
        exp_q.push_back({32'(e1 + 33), 1'b0, hold_x, hold_y});
        repeat (3) @(negedge clk);
        vif.v_sync_in = 1'b0;
        wait_drain("back_to_back");
    endtask

    task automatic test_random();
        int e0;
        int cnt;
        clear_mask();
        cnt = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if ($urandom_range(0, 15) == 0) begin
                    set_px(x, y);
                    cnt++;
                end
        if (cnt == 0) set_px(17, 42);
        drive_frame();
        end_frame(1'b1, e0);
        wait_drain("random");
    endtask

    // ---------------- sequence ----------------
    initial begin
        vif.de_in     = 1'b0;
        vif.h_sync_in = 1'b0;
        vif.v_sync_in = 1'b0;
        vif.mask_in   = 1'b0;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_single_pixel();
        test_block();
        test_corners_and_full();
        test_empty_frame();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/centroid_calc.md
# centroid_calc

Computes the centroid of a binary object mask over one video frame and produces the `x_center`/`y_center` coordinates consumed by the crosshair overlay stage. It sits upstream of the overlay in the video chain, fed by the thresholding/mask stage. It accumulates zeroth and first moments while `de_in` is active, snapshots them on the rising edge of `v_sync_in`, and divides them with a sequential divider during vertical blanking. Sync and data signals pass through with the same 3-cycle delay used by the other video stages.

## Interface
- `IMG_W`, 64, active pixels per line; max 1280.
- `IMG_H`, 64, active lines per frame; max 720.

- `clk`  in  1  pixel clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `de_in`  in  1  data enable, one active pixel per cycle when high.
- `h_sync_in`  in  1  horizontal sync.
- `v_sync_in`  in  1  vertical sync, active high.
- `mask_in`  in  1  1 = object pixel; sampled only when `de_in`=1.
- `de_out`, `h_sync_out`, `v_sync_out`  out  1 each  inputs delayed exactly 3 cycles.
- `x_center`  out  11  centroid column, floor(Σx/N).
- `y_center`  out  11  centroid row, floor(Σy/N).
- `center_valid`  out  1  one-cycle pulse when new coordinates are loaded.
- `no_object`  out  1  1 if the last completed frame had N=0.
- `busy`  out  1  high while the divider runs.

## Operation
- Position counters `x_pos`/`y_pos` (11 bit): cleared while `v_sync_in`=1. Otherwise, on each `de_in`=1, `x_pos` increments. At `IMG_W-1`, `x_pos` wraps to 0 and `y_pos` increments. `y_pos` wraps to 0 after `IMG_H-1`.
- Accumulators, updated when `de_in`=1, `v_sync_in`=0 and `mask_in`=1:
  - N += 1 (20 bit).
  - Sx += `x_pos` (32 bit).
  - Sy += `y_pos` (32 bit).
  - `v_sync_in` has priority: a pixel coinciding with vsync high is not accumulated.
- Frame end is detected when `v_sync_in`=1 and `prev_vsync`=0. On that edge:
  - N, Sx and Sy are copied into divider registers.
  - The accumulators are cleared.
  - The FSM enters DIV.
- FSM states:
  - IDLE: wait for frame end.
  - DIV: two parallel 32/20 restoring dividers (Sx/N, Sy/N), one quotient bit per cycle, 32 iterations; the iteration counter is 6 bit.
  - LOAD: write the low 11 quotient bits to `x_center`/`y_center`, pulse `center_valid`, return to IDLE.
- N=0 at snapshot: skip DIV and go straight to LOAD. `x_center`/`y_center` hold their previous values, `no_object`=1, `center_valid` still pulses. Otherwise `no_object`=0 at LOAD.
- A frame end detected in DIV or LOAD restarts the divider with the new snapshot. The previous result is discarded and no `center_valid` pulse is issued for it.
- Quotient never exceeds `IMG_W-1`/`IMG_H-1`, so 11-bit truncation is lossless.
- Accumulation continues normally during DIV; the divider uses only snapshot registers.

## Timing
- Reset values:
  - `x_center`=0, `y_center`=0, `center_valid`=0, `no_object`=1, `busy`=0.
  - The delay line is cleared, so `de_out`/`h_sync_out`/`v_sync_out`=0 for 3 cycles after reset.
  - Accumulators, counters and `prev_vsync` = 0; FSM = IDLE.
- Reset asserted mid-division aborts the division with no `center_valid` pulse.
- Latency, with edge E0 being the edge that samples the vsync rise:
  - `busy`=1 after E0; iterations occur on E1..E32.
  - LOAD on E33: outputs updated and `center_valid`=1 for the cycle following E33.
  - `busy`=0 after E33.
- N=0 case: LOAD on E1, so `center_valid` is high for the cycle following E1.
- Outputs are stable between `center_valid` pulses. Vertical blanking must be at least 34 cycles; this is always met for standard timings.

## Test plan
- IMG 64×64, single mask pixel at (10,20) → after vsync rise: `x_center`=10, `y_center`=20, `no_object`=0, `center_valid` one cycle at E0+33 (the cycle following E33).
- 4×4 block at x,y ∈ [8,11] → Σx=Σy=152, N=16 → `x_center`=`y_center`=9 (floor of 9.5).
- Pixels at (0,0) and (63,63) → 31, 31. Then a full-frame mask → 31, 31, confirming 32-bit sums and no overflow.
- Frame 1 gives (10,20); frame 2 is empty → `no_object`=1, centers remain (10,20), `center_valid` pulses at E0+1 (the cycle following E1).
- Assert `rst` at E0+10 during DIV → no `center_valid`, all outputs at reset values. The next frame with pixel (5,7) → (5,7).
- Second vsync rise at E0+15 (forced short blanking) → only one `center_valid`, 33 cycles after the second rise, carrying the second frame's result. `de_out`/`h_sync_out`/`v_sync_out` track their inputs with exactly 3 cycles of delay throughout.
